multi_matmul_out_drain: RTL

//  Output-side counterpart of the multi-matmul wrapper: captures all TOTAL_INPUT_W lane results on
//  the rising edge of the wrapper's acc_done_wrap, then streams them one CHUNK (WIDTH_OUT*CHUNK_SIZE

---
 rtl/matmul_pkg.sv | 45 ++++
 rtl/matmul_beat_mux.sv | 38 +++
 rtl/multi_matmul_out_drain.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
//   Types and derived-size helpers used by the multi-matmul wrapper and its
//   output drain. All size helpers are constant functions, so parameter
//   declarations can call them.
//
//   state_e           : drain FSM states (IDLE, CAPT, DRAIN, DONE)
//   calc_beat_w()     : bits per beat   = WIDTH_OUT * CHUNK_SIZE
//   calc_slices()     : beats per lane  = NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES
//   calc_lane_w()     : bits per lane   = BEAT_W * SLICES
//   calc_beats()      : beats per frame = TOTAL_INPUT_W * SLICES
//   calc_cnt_w()      : counter width able to index n items (at least 1 bit)
// -----------------------------------------------------------------------------
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int calc_beat_w(input int width_out, input int chunk_size);
    return width_out * chunk_size;
  endfunction

  function automatic int calc_slices(input int cores_a, input int cores_b,
                                     input int modules);
    return cores_a * cores_b * modules;
  endfunction

  function automatic int calc_lane_w(input int beat_w, input int slices);
    return beat_w * slices;
  endfunction

  function automatic int calc_beats(input int lanes, input int slices);
    return lanes * slices;
  endfunction

  // A single-item counter still needs one bit of storage.
  function automatic int calc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_beat_mux.sv
// -----------------------------------------------------------------------------
// matmul_beat_mux
//   Combinational beat selector. Beat k of a frame is slice (k % SLICES) of
//   lane (k / SLICES); slice 0 occupies the LSBs of the lane word.
//
//   Ports
//     buf_i        in  LANE_W x LANES   captured lane words
//     beat_idx_i   in  CNT_W            beat index within the frame
//     beat_data_o  out BEAT_W           selected beat payload
// -----------------------------------------------------------------------------
module matmul_beat_mux
  import matmul_pkg::*;
#(
  parameter int BEAT_W = 64,
  parameter int SLICES = 8,
  parameter int LANES  = 2,
  parameter int CNT_W  = 4,
  localparam int LANE_W = calc_lane_w(BEAT_W, SLICES)
) (
  input  logic [LANE_W-1:0] buf_i [LANES],
  input  logic [CNT_W-1:0]  beat_idx_i,
  output logic [BEAT_W-1:0] beat_data_o
);

  // Flat compare against every (lane, slice) pair; indices outside the frame
  // select zero.
  always_comb begin
    beat_data_o = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLICES; s++) begin
        if (beat_idx_i == CNT_W'(l * SLICES + s)) begin
          beat_data_o = buf_i[l][s*BEAT_W +: BEAT_W];
        end
      end
    end
  end

endmodule

// File: rtl/multi_matmul_out_drain.sv
// -----------------------------------------------------------------------------
// multi_matmul_out_drain
//   Captures every lane result of the multi-matmul wrapper on the rising edge
//   of acc_done_wrap, then streams the frame one BEAT_W chunk per beat into a
//   BRAM write port under valid/ready handshaking.
//
//   Ports
//     clk               in   clock
//     rst_n             in   asynchronous active-low reset
//     acc_done_wrap     in   accumulation done level (rising edge starts a frame)
//     out_multi_matmul  in   LANE_W x TOTAL_INPUT_W per-lane results
//     base_addr         in   first write address, sampled with the lanes
//     out_valid         out  beat valid
//     out_ready         in   sink accepts beat
//     out_data          out  beat payload
//     out_addr          out  beat write address (base + beat, wraps)
//     out_last          out  final beat of the frame
//     busy              out  frame in progress (CAPT / DRAIN / DONE)
//     frame_done        out  one-cycle pulse after the last beat is accepted
//     overrun           out  one-cycle pulse: start edge seen while busy, dropped
// -----------------------------------------------------------------------------
module multi_matmul_out_drain
  import matmul_pkg::*;
#(
  parameter int WIDTH_OUT     = 16,
  parameter int CHUNK_SIZE    = 4,
  parameter int NUM_CORES_A   = 4,
  parameter int NUM_CORES_B   = 1,
  parameter int TOTAL_MODULES = 2,
  parameter int TOTAL_INPUT_W = 2,
  parameter int ADDR_WIDTH    = 10,
  localparam int BEAT_W = calc_beat_w(WIDTH_OUT, CHUNK_SIZE),
  localparam int SLICES = calc_slices(NUM_CORES_A, NUM_CORES_B, TOTAL_MODULES),
  localparam int LANE_W = calc_lane_w(BEAT_W, SLICES),
  localparam int BEATS  = calc_beats(TOTAL_INPUT_W, SLICES),
  localparam int CNT_W  = calc_cnt_w(BEATS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  acc_done_wrap,
  input  logic [LANE_W-1:0]     out_multi_matmul [TOTAL_INPUT_W],
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BEAT_W-1:0]     out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e                  state_q;
  logic                    acc_done_q;
  logic                    start;
  logic                    fire;
  logic [CNT_W-1:0]        beat_q;
  logic [CNT_W-1:0]        beat_d;
  logic                    valid_q;
  logic                    last_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    ovr_q;
  logic [LANE_W-1:0]       buf_q [TOTAL_INPUT_W];
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [BEAT_W-1:0]       mux_data;

  assign start  = acc_done_wrap & ~acc_done_q;
  assign fire   = valid_q & out_ready;
  assign beat_d = beat_q + CNT_W'(1);

  // ---- edge detect ----------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_done_q <= 1'b0;
    end else begin
      acc_done_q <= acc_done_wrap;
    end
  end

  // ---- capture buffer -------------------------------------------------------
  // Data-only storage: loaded only on an accepted start, so later changes on
  // the inputs cannot disturb a frame already being drained.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      buf_q  <= out_multi_matmul;
      base_q <= base_addr;
    end
  end

  // ---- drain FSM ------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // A start edge outside IDLE is dropped and flagged one cycle later.
      ovr_q  <= start && (state_q != ST_IDLE);
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_CAPT;
            busy_q  <= 1'b1;
            beat_q  <= '0;
          end
        end
        ST_CAPT: begin
          state_q <= ST_DRAIN;
          valid_q <= 1'b1;
          last_q  <= (LAST_BEAT == '0);
        end
        ST_DRAIN: begin
          // Only a transfer moves the beat; during a stall everything holds.
          if (fire) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_d;
              last_q <= (beat_d == LAST_BEAT);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---- beat select ----------------------------------------------------------
  matmul_beat_mux #(
    .BEAT_W (BEAT_W),
    .SLICES (SLICES),
    .LANES  (TOTAL_INPUT_W),
    .CNT_W  (CNT_W)
  ) u_beat_mux (
    .buf_i       (buf_q),
    .beat_idx_i  (beat_q),
    .beat_data_o (mux_data)
  );

  // Payload and address are forced to zero outside a valid beat so the
  // uninitialised buffer never shows on the port after reset.
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign out_data   = valid_q ? mux_data : '0;
  assign out_addr   = valid_q ? (base_q + ADDR_WIDTH'(beat_q)) : '0;

endmodule
